// File: rtl/frame_capture_pkg.sv
// Shared types and default geometry for the frame capture block.
package frame_capture_pkg;

    localparam int DEFAULT_WORD_SIZE = 8;
    localparam int DEFAULT_ROW_SIZE  = 10;
    localparam int DEFAULT_COL_SIZE  = 10;
    localparam int DEFAULT_SKIP      = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_capture_if.sv
// Control, pixel-stream and host-read signals of frame_capture bundled as one interface.
interface frame_capture_if
    import frame_capture_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int ADDR_W    = width_of(DEFAULT_ROW_SIZE * DEFAULT_COL_SIZE)
);
    logic                 start;
    logic                 in_valid;
    logic [WORD_SIZE-1:0] in_pixel;
    logic                 busy;
    logic                 frame_done;
    logic                 overflow;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 rd_valid;

    modport master (
        output start, in_valid, in_pixel, rd_en, rd_addr,
        input  busy, frame_done, overflow, rd_data, rd_valid
    );

    modport slave (
        input  start, in_valid, in_pixel, rd_en, rd_addr,
        output busy, frame_done, overflow, rd_data, rd_valid
    );
endinterface

// File: rtl/frame_capture_ram.sv
// capture_ram: single write port, registered read port returning pre-write data.
module capture_ram #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 100,
    parameter int ADDR_W    = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 rd_valid
);
    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/frame_capture.sv
// Arms on start, drops SKIP leading beats, then stores one ROW_SIZE x COL_SIZE frame.
// Optional build macro FRAME_CAPTURE_BORDER_ZERO_EN writes 0 for frame-border pixels.
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int ROW_SIZE  = DEFAULT_ROW_SIZE,
    parameter int COL_SIZE  = DEFAULT_COL_SIZE,
    parameter int SKIP      = DEFAULT_SKIP
) (
    input  logic           clock,
    input  logic           reset,
    frame_capture_if.slave bus
);
    localparam int N      = ROW_SIZE * COL_SIZE;
    localparam int ADDR_W = width_of(N);
    localparam int ROW_W  = width_of(COL_SIZE);
    localparam int COL_W  = width_of(ROW_SIZE);

    state_t             state_reg, state_next;
    logic [7:0]         skip_reg, skip_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic               overflow_reg, overflow_next;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WORD_SIZE-1:0] wr_data;
    logic               last_col, last_row;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            skip_reg     <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            skip_reg     <= skip_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        skip_next     = skip_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        overflow_next = overflow_reg;
        wr_en         = 1'b0;
        last_col      = (col_reg == COL_W'(ROW_SIZE - 1));
        last_row      = (row_reg == ROW_W'(COL_SIZE - 1));
        wr_addr       = ADDR_W'(row_reg) * ADDR_W'(ROW_SIZE) + ADDR_W'(col_reg);
        wr_data       = bus.in_pixel;
`ifdef FRAME_CAPTURE_BORDER_ZERO_EN
        if ((row_reg == '0) || last_row || (col_reg == '0) || last_col) begin
            wr_data = '0;
        end
`endif
        // start wins over any same-cycle beat, which is simply dropped.
        if (bus.start) begin
            state_next    = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
            skip_next     = '0;
            row_next      = '0;
            col_next      = '0;
            overflow_next = 1'b0;
        end else begin
            case (state_reg)
                ST_SKIP: begin
                    if (bus.in_valid) begin
                        skip_next = skip_reg + 8'd1;
                        if (skip_reg == 8'(SKIP - 1)) begin
                            state_next = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (bus.in_valid) begin
                        wr_en = !reset;
                        if (last_col) begin
                            col_next = '0;
                            if (last_row) begin
                                row_next   = '0;
                                state_next = ST_DONE;
                            end else begin
                                row_next = row_reg + ROW_W'(1);
                            end
                        end else begin
                            col_next = col_reg + COL_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.in_valid) begin
                        overflow_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_reg == ST_SKIP) || (state_reg == ST_CAPTURE);
    assign bus.frame_done = (state_reg == ST_DONE);
    assign bus.overflow   = overflow_reg;

    capture_ram #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (N),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (bus.rd_en),
        .rd_addr  (bus.rd_addr),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid)
    );
endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture at default geometry (10x10 frame, 13 skipped beats).
module tb_frame_capture;
    localparam int WS = 8;
    localparam int AW = 7;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    frame_capture_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

    frame_capture #(
        .WORD_SIZE (WS),
        .ROW_SIZE  (10),
        .COL_SIZE  (10),
        .SKIP      (13)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("check %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [7:0] v);
        bus.in_valid = 1'b1;
        bus.in_pixel = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic read(input int a, output logic [7:0] d, output logic v);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 7'(a);
        tick();
        d = bus.rd_data;
        v = bus.rd_valid;
        bus.rd_en = 1'b0;
    endtask

    // Expected stored value for address a when value v was captured there.
    function automatic logic [7:0] exp_pix(input int a, input logic [7:0] v);
`ifdef FRAME_CAPTURE_BORDER_ZERO_EN
        int r = a / 10;
        int c = a % 10;
        if (r == 0 || r == 9 || c == 0 || c == 9) return 8'h00;
`endif
        return v;
    endfunction

    initial begin
        logic [7:0] d;
        logic       v;
        int         busy_low;

        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_pixel = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        reset = 1'b1;
        tick();
        // Reset must dominate start, in_valid and rd_en.
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.rd_en = 1'b1;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.rd_en = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Full frame with value = beat index.
        pulse_start();
        check("arm_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 113; i++) begin
            beat(8'(i));
            if (i == 111) check("pre_last_done", 32'(bus.frame_done), 32'd0);
        end
        check("frame_done", 32'(bus.frame_done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_overflow", 32'(bus.overflow), 32'd0);
        read(0, d, v);  check("a_rd0", 32'(d), 32'(exp_pix(0, 8'd13)));
        check("a_rd0_valid", 32'(v), 32'd1);
        read(99, d, v); check("a_rd99", 32'(d), 32'(exp_pix(99, 8'd112)));
        read(55, d, v); check("a_rd55", 32'(d), 32'(exp_pix(55, 8'd68)));
        read(100, d, v); check("oob_data", 32'(d), 32'd0);
        check("oob_valid", 32'(v), 32'd1);
        read(11, d, v); check("a_rd11", 32'(d), 32'(exp_pix(11, 8'd24)));
        tick();
        check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("idle_rd_hold", 32'(bus.rd_data), 32'(exp_pix(11, 8'd24)));

        // Extra beat in DONE: overflow, no write; start clears it.
        beat(8'h33);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_still_done", 32'(bus.frame_done), 32'd1);
        read(0, d, v); check("ovf_no_write", 32'(d), 32'(exp_pix(0, 8'd13)));
        pulse_start();
        check("ovf_clear", 32'(bus.overflow), 32'd0);
        check("rearm_busy", 32'(bus.busy), 32'd1);

        // Abort after 50 beats; start arrives together with a beat that must be dropped.
        for (int i = 0; i < 50; i++) beat(8'(i));
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_pixel = 8'h55;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 112; i++) beat(8'hAA);
        check("abort_not_early", 32'(bus.frame_done), 32'd0);
        beat(8'hAA);
        check("abort_done", 32'(bus.frame_done), 32'd1);
        check("abort_no_ovf", 32'(bus.overflow), 32'd0);
        for (int a = 0; a < 100; a++) begin
            read(a, d, v);
            check($sformatf("aa_rd%0d", a), 32'(d), 32'(exp_pix(a, 8'hAA)));
        end

        // Gapped stream; one beat collides with a read of the same address.
        pulse_start();
        busy_low = 0;
        for (int i = 0; i < 113; i++) begin
            int gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                if (!bus.busy) busy_low++;
            end
            if (i == 68) begin
                bus.rd_en = 1'b1; bus.rd_addr = 7'd55;
            end
            beat(8'(i));
            if (i == 68) begin
                bus.rd_en = 1'b0;
                check("rw_old_data", 32'(bus.rd_data), 32'(exp_pix(55, 8'hAA)));
            end
            if (i < 112 && !bus.busy) busy_low++;
        end
        check("gap_busy_drops", 32'(busy_low), 32'd0);
        check("gap_done", 32'(bus.frame_done), 32'd1);
        for (int a = 0; a < 100; a++) begin
            read(a, d, v);
            check($sformatf("gap_rd%0d", a), 32'(d), 32'(exp_pix(a, 8'(a + 13))));
        end

        // Overflow and start in the same cycle leave overflow clear.
        bus.start = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b0;
        check("ovf_start_same", 32'(bus.overflow), 32'd0);
        check("ovf_start_busy", 32'(bus.busy), 32'd1);

        // Reset mid-capture: 13 skipped + 7 stored at addresses 0..6.
        for (int i = 0; i < 20; i++) beat(8'h11);
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.frame_done), 32'd0);
        check("mrst_rd_data", 32'(bus.rd_data), 32'd0);
        read(100, d, v); check("mrst_oob_data", 32'(d), 32'd0);
        check("mrst_oob_valid", 32'(v), 32'd1);
        read(3, d, v);  check("mrst_kept3", 32'(d), 32'(exp_pix(3, 8'h11)));
        read(50, d, v); check("mrst_kept50", 32'(d), 32'(exp_pix(50, 8'd63)));
        beat(8'h77);
        check("idle_ignores_beat", 32'(bus.busy), 32'd0);
        read(1, d, v); check("idle_no_write", 32'(d), 32'(exp_pix(1, 8'h11)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, pixel width in bits.
REQ-002 SHALL have parameter ROW_SIZE, default 10, pixels per line.
REQ-003 SHALL have parameter COL_SIZE, default 10, lines per frame; N = ROW_SIZE*COL_SIZE.
REQ-004 SHALL have parameter SKIP, default 13, leading valid beats discarded after arm; range 0..255.
REQ-005 SHALL have port clock  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  single-cycle pulse arming a capture.
REQ-008 SHALL have port in_valid  input  1  in_pixel is a valid beat this cycle.
REQ-009 SHALL have port in_pixel  input  WORD_SIZE  filtered pixel, raster order.
REQ-010 SHALL have port busy  output  1  high in SKIP or CAPTURE.
REQ-011 SHALL have port frame_done  output  1  high while in DONE.
REQ-012 SHALL have port overflow  output  1  sticky: a beat arrived while in DONE.
REQ-013 SHALL have port rd_en  input  1  host read request.
REQ-014 SHALL have port rd_addr  input  $clog2(N)  raster read address.
REQ-015 SHALL have port rd_data  output  WORD_SIZE  read data, one cycle after rd_en.
REQ-016 SHALL have port rd_valid  output  1  rd_data valid, one cycle after rd_en.

Function
REQ-017 SHALL implement FSM states IDLE, SKIP, CAPTURE, DONE.
REQ-018 IDLE: in_valid ignored; start -> SKIP with skip counter 0 (or CAPTURE directly when SKIP=0).
REQ-019 SKIP: each in_valid beat increments skip counter and is not stored; beat number SKIP moves state to CAPTURE next cycle.
REQ-020 CAPTURE: each in_valid beat writes in_pixel to memory at address row*ROW_SIZE+col, then advances col; col wraps from ROW_SIZE-1 to 0 and increments row.
REQ-021 Beat at row=COL_SIZE-1, col=ROW_SIZE-1 SHALL be written and SHALL move state to DONE next cycle; row and col return to 0.
REQ-022 DONE: no memory writes; in_valid sets overflow; start re-arms per REQ-018.
REQ-023 start in SKIP or CAPTURE SHALL abort and restart at SKIP with counters zeroed; memory contents retained; start takes priority over a same-cycle in_valid beat, which is dropped.
REQ-024 start SHALL clear overflow; overflow set and start in same cycle -> overflow 0.
REQ-025 Read port: independent of FSM, usable in any state; rd_data/rd_valid registered, latency exactly 1 cycle.
REQ-026 Read and write to same address in same cycle SHALL return the old content.
REQ-027 rd_addr >= N SHALL return rd_data 0 with rd_valid 1.
REQ-028 rd_valid SHALL be 0 in cycles following rd_en=0; rd_data holds its last value.
REQ-029 No beat SHALL ever be stored twice or skipped inside CAPTURE; exactly N writes per completed frame.

Reset
REQ-030 Reset SHALL force IDLE and zero the skip, row and col counters.
REQ-031 Reset values: busy 0, frame_done 0, overflow 0, rd_valid 0, rd_data 0.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Reset SHALL dominate start, in_valid and rd_en in the same cycle.

Configuration
REQ-034 Macro FRAME_CAPTURE_BORDER_ZERO_EN defined: beats with row 0, row COL_SIZE-1, col 0 or col ROW_SIZE-1 SHALL write 0 instead of in_pixel.
REQ-035 Macro undefined: every captured beat SHALL be written unmodified; the port list is identical in both builds.

Structure
REQ-036 Shared package SHALL hold the FSM state enum and default WORD_SIZE/ROW_SIZE/COL_SIZE constants.
REQ-037 Memory SHALL be a sub-module capture_ram (N x WORD_SIZE, one write port, one registered read port, read-old-data).

Verification
REQ-038 Defaults, start, 113 beats with value = beat index mod 256 -> frame_done on cycle after beat 113; rd_addr 0 returns 13, rd_addr 99 returns 112.
REQ-039 Defaults, in_valid gaps of 1-3 cycles randomly inserted -> same memory image as REQ-038; busy high throughout.
REQ-040 After DONE, one extra beat -> overflow 1; then start -> overflow 0, busy 1.
REQ-041 start after beat 50 of a capture, then 113 beats of value 0xAA -> all 100 addresses read 0xAA.
REQ-042 FRAME_CAPTURE_BORDER_ZERO_EN defined, 113 beats of 0xFF -> addresses 0, 9, 10, 90, 99 read 0; address 11 reads 0xFF.
REQ-043 Reset asserted mid-CAPTURE -> next cycle busy 0, frame_done 0; rd_addr 100 returns 0 with rd_valid 1.
